// File: rtl/ram_pkg.sv
// ram_pkg: controller state type, read-during-write mode codes and the byte-lane merge helper
// shared by the clear controller and the dual-port RAM (optional macro: RAM_OUTREG_EN).
package ram_pkg;
   typedef enum logic {RAM_INIT, RAM_READY} ram_state_e;
   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;
   function automatic logic [7:0] byte_merge(input logic [7:0] old_b, input logic [7:0] new_b,
                                             input logic be);
      return be ? new_b : old_b;
   endfunction
endpackage

// File: rtl/ram_init_ctrl.sv
// ram_init_ctrl: after reset, sweeps every word address once to zero the array, then
// stays READY until the next reset.
module ram_init_ctrl
   import ram_pkg::*;
#(
   parameter int DEPTH = 10
) (
   input  logic             clock,
   input  logic             reset,
   output logic             init_busy_o,
   output logic             clr_we_o,
   output logic [DEPTH-1:0] clr_addr_o
);
   ram_state_e       state_q, state_d;
   logic [DEPTH-1:0] ptr_q, ptr_d;
   logic             busy_q, busy_d;
   always_comb begin
      state_d = (state_q == RAM_INIT && &ptr_q) ? RAM_READY : state_q;
      ptr_d   = (state_q == RAM_INIT) ? ptr_q + 1'b1 : ptr_q;
      busy_d  = (state_d == RAM_INIT);
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= RAM_INIT;
         ptr_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
      end
   end
   assign init_busy_o = busy_q;
   assign clr_we_o    = busy_q;
   assign clr_addr_o  = ptr_q;
endmodule

// File: rtl/ram_2port_be_init.sv
// ram_2port_be_init: byte-enabled read/write port A plus read port B over one array, zeroed by
// a clear engine after reset. RAM_OUTREG_EN adds an output register stage on both ports.
module ram_2port_be_init
   import ram_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 10,
   parameter int RDW_MODE = RDW_OLD
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [DEPTH-1:0]   a_address,
   input  logic [WIDTH/8-1:0] a_byteena,
   input  logic [WIDTH-1:0]   a_data,
   input  logic               a_wren,
   input  logic               a_rden,
   output logic [WIDTH-1:0]   a_q,
   output logic               a_valid,
   input  logic [DEPTH-1:0]   b_address,
   input  logic               b_rden,
   output logic [WIDTH-1:0]   b_q,
   output logic               b_valid,
   output logic               init_busy
);
   localparam int NB = WIDTH / 8;
   logic [WIDTH-1:0] mem [2**DEPTH];
   logic             clr_we, ready, we;
   logic [DEPTH-1:0] clr_addr, wr_addr;
   logic [WIDTH-1:0] a_old, b_old, a_merged, a_rd, b_rd, wr_data;
   logic [WIDTH-1:0] a_q1_q, b_q1_q;
   logic             a_v1_q, b_v1_q;
   ram_init_ctrl #(.DEPTH(DEPTH)) u_init (
      .clock      (clock),
      .reset      (reset),
      .init_busy_o(init_busy),
      .clr_we_o   (clr_we),
      .clr_addr_o (clr_addr)
   );
   // The merged word is both what port A writes and what RDW_NEW forwards to readers.
   always_comb begin
      a_old    = mem[a_address];
      b_old    = mem[b_address];
      a_merged = a_old;
      for (int i = 0; i < NB; i++)
         a_merged[8*i+:8] = byte_merge(a_old[8*i+:8], a_data[8*i+:8], a_byteena[i]);
      ready   = !init_busy;
      we      = clr_we | (ready & a_wren);
      wr_addr = clr_we ? clr_addr : a_address;
      wr_data = clr_we ? '0 : a_merged;
      a_rd    = (RDW_MODE == RDW_NEW && a_wren) ? a_merged : a_old;
      b_rd    = (RDW_MODE == RDW_NEW && a_wren && b_address == a_address) ? a_merged : b_old;
   end
   always_ff @(posedge clock) begin
      if (we) mem[wr_addr] <= wr_data;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         a_q1_q <= '0;
         b_q1_q <= '0;
         a_v1_q <= 1'b0;
         b_v1_q <= 1'b0;
      end else begin
         a_v1_q <= ready & a_rden;
         b_v1_q <= ready & b_rden;
         if (ready & a_rden) a_q1_q <= a_rd;
         if (ready & b_rden) b_q1_q <= b_rd;
      end
   end
`ifdef RAM_OUTREG_EN
   logic [WIDTH-1:0] a_q2_q, b_q2_q;
   logic             a_v2_q, b_v2_q;
   always_ff @(posedge clock) begin
      if (reset) begin
         a_q2_q <= '0;
         b_q2_q <= '0;
         a_v2_q <= 1'b0;
         b_v2_q <= 1'b0;
      end else begin
         a_v2_q <= a_v1_q;
         b_v2_q <= b_v1_q;
         if (a_v1_q) a_q2_q <= a_q1_q;
         if (b_v1_q) b_q2_q <= b_q1_q;
      end
   end
   assign a_q     = a_q2_q;
   assign b_q     = b_q2_q;
   assign a_valid = a_v2_q;
   assign b_valid = b_v2_q;
`else
   assign a_q     = a_q1_q;
   assign b_q     = b_q1_q;
   assign a_valid = a_v1_q;
   assign b_valid = b_v1_q;
`endif
endmodule
